light_mode_controller: RTL

Sequences the bike light's blink patterns by driving the shared `timer` block. Outputs:
- `load_value`, the count enable, and a one-cycle restart to the timer.
- The LED drive level.

---
 rtl/light_mode_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/light_mode_controller.sv
// Bike light mode sequencer: steps OFF/STEADY/BLINK/FLASH on button presses and
// walks the BLINK/FLASH phases on timer expiries, reloading the shared timer.
module light_mode_controller #(
  parameter logic [8:0] BLINK_ON  = 9'd250,
  parameter logic [8:0] BLINK_OFF = 9'd250,
  parameter logic [8:0] FLASH_ON  = 9'd30,
  parameter logic [8:0] FLASH_GAP = 9'd60,
  parameter logic [8:0] FLASH_OFF = 9'd400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_press,
  input  logic       timer_done,
  output logic [8:0] timer_load,
  output logic       timer_restart,
  output logic       timer_count_en,
  output logic       light,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FLASH  = 2'd3
  } mode_t;

  mode_t      mode_q, mode_d;
  logic [1:0] phase_q, phase_d;
  logic       light_d;
  logic [8:0] load_d;
  logic       restart_d;

  // A zero duration would make the timer expire immediately; reject at elaboration.
  if (BLINK_ON == 9'd0 || BLINK_OFF == 9'd0 || FLASH_ON == 9'd0 ||
      FLASH_GAP == 9'd0 || FLASH_OFF == 9'd0) begin : g_bad_param
    $error("light_mode_controller: duration parameters must lie in 1..511");
  end

  function automatic logic [8:0] flash_load(input logic [1:0] ph);
    case (ph)
      2'd1:    return FLASH_GAP;
      2'd3:    return FLASH_OFF;
      default: return FLASH_ON;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_OFF;
      phase_q       <= '0;
      light         <= 1'b0;
      timer_load    <= '0;
      timer_restart <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      light         <= light_d;
      timer_load    <= load_d;
      timer_restart <= restart_d;
    end
  end

  // A press takes priority; a coincident expiry is dropped, not deferred.
  always_comb begin
    mode_d    = mode_q;
    phase_d   = phase_q;
    light_d   = light;
    load_d    = timer_load;
    restart_d = 1'b0;
    if (btn_press) begin
      mode_d    = mode_t'(mode_q + 2'd1);
      phase_d   = '0;
      restart_d = 1'b1;
      light_d   = (mode_d != MODE_OFF);
      if (mode_d == MODE_BLINK)
        load_d = BLINK_ON;
      else if (mode_d == MODE_FLASH)
        load_d = FLASH_ON;
    end else if (timer_done) begin
      case (mode_q)
        MODE_BLINK: begin
          phase_d   = {phase_q[1], ~phase_q[0]};
          light_d   = phase_q[0];
          load_d    = phase_q[0] ? BLINK_ON : BLINK_OFF;
          restart_d = 1'b1;
        end
        MODE_FLASH: begin
          phase_d   = phase_q + 2'd1;
          light_d   = ~phase_d[0];
          load_d    = flash_load(phase_d);
          restart_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign timer_count_en = tick & mode_q[1] & ~timer_restart;
  assign mode           = mode_q;

endmodule
